decode_imm_stage: RTL
=====================

// Module: decode_imm_stage
// PURPOSE
//  Decode/register stage directly upstream of sign_extend #(.N(8)). Accepts 16-bit
//  instruction words from fetch via valid/ready, holds them in a 2-entry skid buffer,
//  and splits each word into fields. The immediate is delivered pre-widened to 8 bits
//  so sign_extend #(.N(8)) yields the 16-bit operand. Sits between fetch and ALU/regfile.
// PARAMETERS
//  IW      16   instruction width (only 16 supported)
//  IMM_W   8    imm_out width; matches downstream sign_extend N
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  flush      in   1   discard all buffered instructions (branch taken)
//  in_valid   in   1   fetch presents instr
//  in_ready   out  1   stage can accept this cycle
//  instr      in   16  instruction word
//  out_valid  out  1   head entry valid
//  out_ready  in   1   downstream consumes head this cycle
//  opcode     out  4   instr[15:12] of head
//  rd         out  4   instr[11:8] of head
//  rs         out  4   instr[7:4] of head
//  func       out  4   instr[3:0] of head (meaningful for opcode 4'hF only)
//  imm_out    out  8   immediate, pre-widened to 8 bits (feeds sign_extend.in)
//  imm_is8    out  1   1: imm from instr[7:0]; 0: imm from instr[3:0]
// BEHAVIOUR
//  - Reset (async, rst=1): count=0, out_valid=0, in_ready=1, all field outputs 0.
//  - Storage: 2-entry FIFO, count in {0,1,2}; head drives all outputs; entry regs only.
//  - in_ready = (count!=2), from registered count only; no comb path from out_ready.
//  - Accept when in_valid&in_ready; pop when out_valid&out_ready; both same edge:
//    count unchanged, new word enqueued behind (or into freed slot if count==1).
//  - Latency: word accepted at edge N appears on outputs after edge N (count 0 -> 1);
//    no combinational bypass from instr to outputs.
//  - out_valid = (count!=0). Outputs hold stable while out_valid&!out_ready.
//  - Immediate select by head opcode:
//      4'h4,4'h5,4'h6 (branches): imm_is8=1, imm_out=instr[7:0]
//      4'h8,4'h9 (load/store):   imm_is8=0, imm_out={{4{instr[3]}},instr[3:0]}
//      all others:               imm_is8=0, imm_out={4'h0,instr[3:0]}
//  - flush: next edge count=0, out_valid=0; flush overrides a simultaneous accept
//    (word dropped, fetch must re-issue) and a simultaneous pop.
//  - When count==0, field outputs are 0 (not stale).
//  - rst asserted mid-transfer clears immediately regardless of clk; first accept
//    possible on the first edge after rst deasserts.
//  - No overflow: accept impossible at count==2; no underflow: pop requires out_valid.
// TESTING
//  1 Reset: rst=1 mid-cycle with count=2 -> out_valid=0, in_ready=1, imm_out=0 at once.
//  2 Branch: accept 16'h45F0, out_ready=1 -> next cycle opcode=4, imm_is8=1,
//    imm_out=8'hF0; sign_extend output 16'hFFF0.
//  3 Load disp: accept 16'h8129 -> imm_out=8'hF9, imm_is8=0 (sign_extend 16'hFFF9);
//    16'h8127 -> imm_out=8'h07.
//  4 Backpressure: out_ready=0, offer 3 words 16'h1111,16'h2222,16'h3333 -> first two
//    taken, in_ready=0 at count 2, 16'h3333 held; release out_ready -> order 1111,2222,3333.
//  5 Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, in_ready=1,
//    stream order preserved, one-cycle latency each word.
//  6 Flush with in_valid=1 and count=2 -> next cycle out_valid=0, count=0, flushed-cycle
//    word absent from output stream.

Source files
------------

// File: rtl/decode_imm_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode/immediate stage.
interface decode_imm_stage_if #(
  parameter int unsigned IW    = 16,
  parameter int unsigned IMM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    instr;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       opcode;
  logic [3:0]       rd;
  logic [3:0]       rs;
  logic [3:0]       func;
  logic [IMM_W-1:0] imm_out;
  logic             imm_is8;

  // Driver side: fetch pushes words and execute drains them.
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, opcode, rd, rs, func, imm_out, imm_is8
  );

  // Stage side.
  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, opcode, rd, rs, func, imm_out, imm_is8
  );
endinterface

// File: rtl/decode_imm_stage.sv
// Decode stage: 2-entry skid buffer of pre-decoded instruction words. Words are
// decoded on entry so every output is a direct register bit.
module decode_imm_stage #(
  parameter int unsigned IW    = 16,
  parameter int unsigned IMM_W = 8
) (
  input logic                clk,
  input logic                rst,
  input logic                flush,
  decode_imm_stage_if.slave  bus
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned FLD_W = 4;

  typedef struct packed {
    logic [FLD_W-1:0] opcode;
    logic [FLD_W-1:0] rd;
    logic [FLD_W-1:0] rs;
    logic [FLD_W-1:0] func;
    logic [IMM_W-1:0] imm;
    logic             imm_is8;
  } entry_t;

  // Split a word into fields and pick the immediate form by opcode.
  function automatic entry_t decode(input logic [IW-1:0] w);
    entry_t e;
    e         = '0;
    e.opcode  = w[15:12];
    e.rd      = w[11:8];
    e.rs      = w[7:4];
    e.func    = w[3:0];
    case (w[15:12])
      4'h4, 4'h5, 4'h6: begin
        e.imm_is8 = 1'b1;
        e.imm     = IMM_W'(w[7:0]);
      end
      4'h8, 4'h9: e.imm = {{(IMM_W-FLD_W){w[3]}}, w[3:0]};
      default:    e.imm = {{(IMM_W-FLD_W){1'b0}}, w[3:0]};
    endcase
    return e;
  endfunction

  logic [CNT_W-1:0] count_q, count_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic             out_valid_q, in_ready_q;
  logic             push, pop;
  entry_t           incoming;

  assign push     = bus.in_valid & in_ready_q;
  assign pop      = out_valid_q & bus.out_ready;
  assign incoming = decode(bus.instr);

  // Next occupancy and entry contents; head is zeroed whenever it empties.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = CNT_W'(0);
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (count_q)
        CNT_W'(0): begin
          if (push) begin
            head_d  = incoming;
            count_d = CNT_W'(1);
          end
        end
        CNT_W'(1): begin
          if (push && pop) begin
            head_d = incoming;
          end else if (push) begin
            tail_d  = incoming;
            count_d = CNT_W'(2);
          end else if (pop) begin
            head_d  = '0;
            count_d = CNT_W'(0);
          end
        end
        default: begin
          if (pop) begin
            head_d  = tail_q;
            tail_d  = '0;
            count_d = CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Entry, occupancy and handshake flags; flags track the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= CNT_W'(0);
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= (count_d != CNT_W'(0));
      in_ready_q  <= (count_d != CNT_W'(2));
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.opcode    = head_q.opcode;
  assign bus.rd        = head_q.rd;
  assign bus.rs        = head_q.rs;
  assign bus.func      = head_q.func;
  assign bus.imm_out   = head_q.imm;
  assign bus.imm_is8   = head_q.imm_is8;

endmodule
